// File: rtl/reg_sel_sb_pkg.sv
// reg_sel_sb_pkg
//   Shared constants for the register select-and-encode unit: default
//   register count, instruction width, ra/rb/rc field positions, and the
//   register index type for the default register count.
package reg_sel_sb_pkg;

    localparam int unsigned NREG_DEF   = 16;
    localparam int unsigned IW_DEF     = 32;
    localparam int unsigned RA_LSB_DEF = 23;
    localparam int unsigned RB_LSB_DEF = 19;
    localparam int unsigned RC_LSB_DEF = 15;

    typedef logic [$clog2(NREG_DEF)-1:0] reg_idx_t;

endpackage

// File: rtl/reg_sel_sb_onehot_dec.sv
// onehot_dec
//   RW-bit index to NREG-bit one-hot decoder. Index values at or above
//   NREG decode to all zeros, so unimplemented registers are never enabled.
//   Ports:
//     sel  in  RW    register index
//     dec  out NREG  one-hot enable vector (zero when sel >= NREG)
module onehot_dec #(
    parameter int unsigned NREG = 16,
    parameter int unsigned RW   = 4
) (
    input  logic [RW-1:0]   sel,
    output logic [NREG-1:0] dec
);

    always_comb begin
        dec = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            dec[i] = (32'(sel) == i);
        end
    end

endmodule

// File: rtl/reg_sel_sb.sv
// reg_sel_sb
//   Register select-and-encode unit with write scoreboard. Latches the
//   ra/rb/rc fields of the instruction, selects one of them under Gra/Grb/Grc
//   priority, and produces registered one-hot load/drive enables for the
//   register file. Outstanding destination writes are tracked per register;
//   a read of a register with a pending write stalls unless the writeback
//   for that register lands in the same cycle.
//   Ports:
//     clk, clear_n           clock, synchronous active-low reset
//     instr, ir_load         instruction word and field latch strobe
//     Gra, Grb, Grc          field select (Gra highest priority)
//     Rin, Rout, BAout       load / drive / base-address read requests
//     issue_wr               mark latched ra as pending write
//     wb_valid, wb_reg       writeback completion
//     ctrl_in, ctrl_out      registered one-hot load / drive enables
//     zero_out               registered constant-zero bus drive
//     stall                  combinational read hazard
//     pending                scoreboard state
module reg_sel_sb
    import reg_sel_sb_pkg::*;
#(
    parameter  int unsigned NREG   = NREG_DEF,
    parameter  int unsigned IW     = IW_DEF,
    parameter  int unsigned RA_LSB = RA_LSB_DEF,
    parameter  int unsigned RB_LSB = RB_LSB_DEF,
    parameter  int unsigned RC_LSB = RC_LSB_DEF,
    localparam int unsigned RW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            clear_n,
    input  logic [IW-1:0]   instr,
    input  logic            ir_load,
    input  logic            Gra,
    input  logic            Grb,
    input  logic            Grc,
    input  logic            Rin,
    input  logic            Rout,
    input  logic            BAout,
    input  logic            issue_wr,
    input  logic            wb_valid,
    input  logic [RW-1:0]   wb_reg,
    output logic [NREG-1:0] ctrl_in,
    output logic [NREG-1:0] ctrl_out,
    output logic            zero_out,
    output logic            stall,
    output logic [NREG-1:0] pending
);

    logic [RW-1:0]   ra_q, rb_q, rc_q;
    logic [RW-1:0]   sel;
    logic [NREG-1:0] dec, ra_dec, wb_dec;
    logic [NREG-1:0] set_vec, clr_vec;
    logic            sel_zero;
    logic            instr_unused;

    // Only the three fields are consumed; the rest of the word is ignored.
    assign instr_unused = ^instr;

    always_comb begin
        sel = '0;
        if (Gra)      sel = ra_q;
        else if (Grb) sel = rb_q;
        else if (Grc) sel = rc_q;
    end

    onehot_dec #(.NREG(NREG), .RW(RW)) u_sel_dec (.sel(sel),    .dec(dec));
    onehot_dec #(.NREG(NREG), .RW(RW)) u_ra_dec  (.sel(ra_q),   .dec(ra_dec));
    onehot_dec #(.NREG(NREG), .RW(RW)) u_wb_dec  (.sel(wb_reg), .dec(wb_dec));

    assign sel_zero = (sel == '0);
    assign set_vec  = issue_wr ? ra_dec : '0;
    assign clr_vec  = wb_valid ? wb_dec : '0;

    // pending & dec is zero for out-of-range sel, so no separate range check.
    assign stall = (Rout | BAout) & (|(pending & dec))
                   & ~(wb_valid & (wb_reg == sel));

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            ctrl_in  <= '0;
            ctrl_out <= '0;
            zero_out <= 1'b0;
            pending  <= '0;
        end else begin
            if (ir_load) begin
                ra_q <= instr[RA_LSB +: RW];
                rb_q <= instr[RB_LSB +: RW];
                rc_q <= instr[RC_LSB +: RW];
            end

            ctrl_in <= Rin ? dec : '0;

            if (stall) begin
                ctrl_out <= '0;
                zero_out <= 1'b0;
            end else if (BAout && sel_zero) begin
                ctrl_out <= '0;
                zero_out <= 1'b1;
            end else if (Rout || BAout) begin
                ctrl_out <= dec;
                zero_out <= 1'b0;
            end else begin
                ctrl_out <= '0;
                zero_out <= 1'b0;
            end

            // Set takes priority over a same-cycle clear of the same register.
            pending <= set_vec | (pending & ~clr_vec);
        end
    end

endmodule

// File: tb/tb_reg_sel_sb.sv
module tb_reg_sel_sb;
    import reg_sel_sb_pkg::*;

    logic        clk = 1'b0;
    logic        clear_n;
    logic [31:0] instr;
    logic        ir_load, Gra, Grb, Grc, Rin, Rout, BAout, issue_wr, wb_valid;
    logic [3:0]  wb_reg;

    logic [15:0] ci16, co16, pd16;
    logic        z16, st16;
    logic [11:0] ci12, co12, pd12;
    logic        z12, st12;

    int ncomp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    reg_sel_sb #(.NREG(16)) dut16 (
        .clk(clk), .clear_n(clear_n), .instr(instr), .ir_load(ir_load),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .issue_wr(issue_wr), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .ctrl_in(ci16), .ctrl_out(co16), .zero_out(z16), .stall(st16), .pending(pd16)
    );

    reg_sel_sb #(.NREG(12)) dut12 (
        .clk(clk), .clear_n(clear_n), .instr(instr), .ir_load(ir_load),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .issue_wr(issue_wr), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .ctrl_in(ci12), .ctrl_out(co12), .zero_out(z12), .stall(st12), .pending(pd12)
    );

    // Reference model: integer field values and a per-register pending table.
    int nregs [2] = '{16, 12};
    int fa = 0, fb = 0, fc = 0;
    bit pend [2][16];
    int exp_in_idx [2];   // -1 means no enable
    int exp_out_idx [2];
    bit exp_zero [2];
    bit exp_stall [2];

    function automatic logic [15:0] idx_vec(int idx);
        logic [15:0] v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] pend_vec(int k);
        logic [15:0] v = '0;
        for (int i = 0; i < nregs[k]; i++) v[i] = pend[k][i];
        return v;
    endfunction

    function automatic int cur_sel();
        if (Gra) return fa;
        if (Grb) return fb;
        if (Grc) return fc;
        return 0;
    endfunction

    function automatic void model_comb();
        int s = cur_sel();
        for (int k = 0; k < 2; k++) begin
            exp_stall[k] = (Rout || BAout) && (s < nregs[k]) && pend[k][s]
                           && !(wb_valid && int'(wb_reg) == s);
        end
    endfunction

    function automatic void model_seq();
        int s = cur_sel();
        if (!clear_n) begin
            fa = 0; fb = 0; fc = 0;
            for (int k = 0; k < 2; k++) begin
                exp_in_idx[k] = -1; exp_out_idx[k] = -1; exp_zero[k] = 0;
                for (int i = 0; i < 16; i++) pend[k][i] = 0;
            end
            return;
        end
        for (int k = 0; k < 2; k++) begin
            int n = nregs[k];
            exp_in_idx[k] = (Rin && s < n) ? s : -1;
            exp_out_idx[k] = -1;
            exp_zero[k] = 0;
            if (exp_stall[k]) begin
            end else if (BAout && s == 0) exp_zero[k] = 1;
            else if ((Rout || BAout) && s < n) exp_out_idx[k] = s;
            if (wb_valid && int'(wb_reg) < n) pend[k][wb_reg] = 0;
            if (issue_wr && fa < n) pend[k][fa] = 1;
        end
        if (ir_load) begin
            fa = int'(instr[RA_LSB_DEF +: 4]);
            fb = int'(instr[RB_LSB_DEF +: 4]);
            fc = int'(instr[RC_LSB_DEF +: 4]);
        end
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_comb();
        if (clear_n) begin
            chk("stall16", {15'd0, st16}, {15'd0, exp_stall[0]});
            chk("stall12", {15'd0, st12}, {15'd0, exp_stall[1]});
        end
        @(posedge clk);
        model_seq();
        #1;
        chk("ctrl_in16",  ci16, idx_vec(exp_in_idx[0]));
        chk("ctrl_out16", co16, idx_vec(exp_out_idx[0]));
        chk("zero_out16", {15'd0, z16}, {15'd0, exp_zero[0]});
        chk("pending16",  pd16, pend_vec(0));
        chk("ctrl_in12",  {4'd0, ci12}, idx_vec(exp_in_idx[1]));
        chk("ctrl_out12", {4'd0, co12}, idx_vec(exp_out_idx[1]));
        chk("zero_out12", {15'd0, z12}, {15'd0, exp_zero[1]});
        chk("pending12",  {4'd0, pd12}, pend_vec(1));
    endtask

    task automatic idle();
        clear_n = 1'b1; ir_load = 0; Gra = 0; Grb = 0; Grc = 0;
        Rin = 0; Rout = 0; BAout = 0; issue_wr = 0; wb_valid = 0; wb_reg = '0;
    endtask

    function automatic logic [31:0] mk_instr(int ra, int rb, int rc);
        logic [31:0] w = $urandom;
        w[RA_LSB_DEF +: 4] = 4'(ra);
        w[RB_LSB_DEF +: 4] = 4'(rb);
        w[RC_LSB_DEF +: 4] = 4'(rc);
        return w;
    endfunction

    task automatic load(int ra, int rb, int rc);
        idle(); instr = mk_instr(ra, rb, rc); ir_load = 1; step();
    endtask

    initial begin
        reg_idx_t r;
        // Reset with every input high.
        clear_n = 0; instr = '1; ir_load = 1; Gra = 1; Grb = 1; Grc = 1;
        Rin = 1; Rout = 1; BAout = 1; issue_wr = 1; wb_valid = 1; wb_reg = '1;
        #1; step(); step();
        idle(); step();
        chk("reset_pending16", pd16, 16'h0000);

        // Field decode.
        load(5, 3, 9);
        idle(); Grb = 1; Rout = 1; Rin = 1; step();
        chk("decode_out16", co16, 16'h0008);
        // Rc and Ra selection too.
        idle(); Grc = 1; Rout = 1; step();
        idle(); Gra = 1; Grb = 1; Rin = 1; step();

        // BAout on R0 and on R7.
        load(5, 0, 9);
        idle(); Grb = 1; BAout = 1; step();
        chk("ba_r0_zero16", {15'd0, z16}, 16'h0001);
        load(5, 7, 9);
        idle(); Grb = 1; BAout = 1; step();
        chk("ba_r7_out16", co16, 16'h0080);
        // No Gr*: Rout reads R0, BAout gives zero.
        idle(); Rout = 1; step();
        idle(); BAout = 1; step();

        // Hazard and writeback bypass.
        load(4, 1, 2);
        idle(); issue_wr = 1; step();
        chk("hazard_pend16", pd16, 16'h0010);
        idle(); Gra = 1; Rout = 1; step();
        idle(); Gra = 1; Rout = 1; wb_valid = 1; wb_reg = 4; step();
        chk("bypass_out16", co16, 16'h0010);
        idle(); step();

        // Set/clear collision on R6, plus issue_wr with ir_load (old ra marked).
        load(6, 1, 2);
        idle(); issue_wr = 1; step();
        idle(); issue_wr = 1; wb_valid = 1; wb_reg = 6; step();
        chk("collide_pend16", pd16[6 +: 1], 1'b1);
        idle(); instr = mk_instr(2, 2, 2); ir_load = 1; issue_wr = 1; step();
        idle(); wb_valid = 1; wb_reg = 2; step();  // clear of non-pending reg
        idle(); wb_valid = 1; wb_reg = 6; step();

        // Out-of-range index for the 12-register instance.
        load(13, 13, 13);
        idle(); issue_wr = 1; Gra = 1; Rout = 1; Rin = 1; step();
        idle(); Gra = 1; Rout = 1; step();
        idle(); wb_valid = 1; wb_reg = 13; Grc = 1; BAout = 1; step();
        idle(); wb_valid = 1; wb_reg = 15; step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            clear_n  = ($urandom_range(0, 49) != 0);
            instr    = $urandom;
            ir_load  = ($urandom_range(0, 2) == 0);
            Gra      = $urandom_range(0, 1) == 1;
            Grb      = $urandom_range(0, 1) == 1;
            Grc      = $urandom_range(0, 1) == 1;
            Rin      = $urandom_range(0, 1) == 1;
            Rout     = $urandom_range(0, 1) == 1;
            BAout    = ($urandom_range(0, 3) == 0);
            issue_wr = ($urandom_range(0, 2) == 0);
            wb_valid = ($urandom_range(0, 2) == 0);
            r        = reg_idx_t'($urandom_range(0, 15));
            wb_reg   = r;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/reg_sel_sb.md
Name: reg_sel_sb

Overview:
- Parametrised register select-and-encode unit for the datapath register file.
- Latches the instruction's ra/rb/rc fields and produces registered one-hot register-file in/out enables.
- Tracks outstanding destination writes in a scoreboard and raises stall when a read targets a register with a write still pending.
- Sits between the control unit and the register file, replacing the purely combinational select/encode path.

Parameters:
- NREG, 16, number of general registers (2..32).
- RW, $clog2(NREG), register index width. Derived; must not be overridden.
- IW, 32, instruction width.
- RA_LSB, 23, LSB of the ra field in the instruction.
- RB_LSB, 19, LSB of the rb field.
- RC_LSB, 15, LSB of the rc field.

Ports:
- clk  in  1  rising-edge clock
- clear_n  in  1  synchronous reset, active low
- instr  in  IW  instruction word
- ir_load  in  1  latch ra/rb/rc from instr
- Gra  in  1  select ra field
- Grb  in  1  select rb field
- Grc  in  1  select rc field
- Rin  in  1  write-enable request for the selected register
- Rout  in  1  read-enable request for the selected register
- BAout  in  1  base-address read request (R0 reads as zero)
- issue_wr  in  1  mark latched ra as pending write
- wb_valid  in  1  writeback completes
- wb_reg  in  RW  register whose write completes
- ctrl_in  out  NREG  one-hot register-file load enables (registered)
- ctrl_out  out  NREG  one-hot register-file drive enables (registered)
- zero_out  out  1  drive constant zero onto bus (registered)
- stall  out  1  read hazard (combinational)
- pending  out  NREG  scoreboard state

Behaviour:
- Reset: on a clk edge with clear_n=0, the following all go to 0. clear_n dominates every other input, including a transaction in progress.
  - field registers ra_q/rb_q/rc_q
  - ctrl_in, ctrl_out, zero_out
  - pending
- Field latch: on ir_load=1, ra_q/rb_q/rc_q <= instr[*_LSB +: RW].
  - Selection in the same cycle uses the old field values; new fields are usable from the next cycle.
- Selection (combinational): sel = Gra ? ra_q : Grb ? rb_q : Grc ? rc_q : 0. Gr* are priority-encoded with Gra highest.
- dec = one-hot(sel); all zeros if sel >= NREG.
- stall = (Rout | BAout) & pending[sel] & ~(wb_valid & wb_reg==sel).
  - A writeback in the same cycle bypasses the hazard.
- Registered outputs, 1-cycle latency. At the next edge:
  - ctrl_in <= Rin ? dec : 0. Rin is never gated by stall.
  - If stall: ctrl_out <= 0, zero_out <= 0.
  - Else if BAout & sel==0: ctrl_out <= 0, zero_out <= 1.
  - Else if Rout | BAout: ctrl_out <= dec, zero_out <= 0.
  - Else: ctrl_out <= 0, zero_out <= 0.
- Rin together with Rout/BAout in the same cycle is legal; both vectors assert.
- Scoreboard, per bit i, at each edge:
  - set_i = issue_wr & ra_q==i
  - clr_i = wb_valid & wb_reg==i
  - pending[i] <= set_i ? 1 : clr_i ? 0 : pending[i]. Set wins over a simultaneous clear of the same register, because a new write has been issued.
- wb_reg >= NREG is ignored. Clearing a register that is not pending is a no-op.
- issue_wr and ir_load in the same cycle: pending marks the old ra_q.
- No Gr* asserted: sel=0, so Rout drives R0 and BAout gives zero_out.

Decomposition:
- Shared package: NREG default, field LSB constants, and a reg_idx_t typedef.
- One sub-module, onehot_dec (RW→NREG one-hot decoder with out-of-range zeroing), replaces the fixed 4-to-16 decoder.

Test Plan:
- Reset: drive all inputs high with clear_n=0 for 2 cycles, then release with inputs low → ctrl_in, ctrl_out, zero_out, pending are all 0.
- Field decode: load instr with ra=5, rb=3, rc=9, then Grb+Rout+Rin for one cycle → next cycle ctrl_out=16'h0008, ctrl_in=16'h0008, stall=0.
- BAout on R0: rb=0, then Grb+BAout → next cycle ctrl_out=0, zero_out=1. Repeat with rb=7 → ctrl_out=16'h0080, zero_out=0.
- Hazard:
  - issue_wr with ra=4 → pending=16'h0010.
  - Gra+Rout → stall=1, next ctrl_out=0.
  - Apply wb_valid with wb_reg=4 in the same cycle → stall=0, ctrl_out=16'h0010; pending clears the following cycle.
- Set/clear collision: pending[6]=1, then issue_wr (ra=6) and wb_valid (wb_reg=6) together → pending[6] stays 1.
- Parameter check: NREG=8, RW=3, wb_reg or field values ≥8 impossible. Then NREG=12 with field value 13 → ctrl_out=0, and wb_reg=13 leaves pending unchanged.
